// File: rtl/mem_pkg.sv
// Shared encodings for the memory access unit: access sizes, FSM states and byte-lane enables.
// Lanes are big-endian: byte offset 0 maps to bits 31:24 (mem_be bit 3).
package mem_pkg;

  localparam logic [1:0] DS_WORD = 2'b00;
  localparam logic [1:0] DS_HALF = 2'b01;
  localparam logic [1:0] DS_BYTE = 2'b10;
  localparam logic [1:0] DS_INV  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    RESP = 2'b10,
    ERR  = 2'b11
  } state_e;

  localparam logic [3:0] BE_NONE    = 4'b0000;
  localparam logic [3:0] BE_WORD    = 4'b1111;
  localparam logic [3:0] BE_HALF_HI = 4'b1100;
  localparam logic [3:0] BE_HALF_LO = 4'b0011;
  localparam logic [3:0] BE_LANE0   = 4'b1000;

  // One-hot enable for a single byte lane at the given offset.
  function automatic logic [3:0] byte_be(input logic [1:0] ofs);
    byte_be = BE_LANE0 >> ofs;
  endfunction

  function automatic logic misaligned(input logic [1:0] ds, input logic [1:0] ofs);
    case (ds)
      DS_WORD: misaligned = (ofs != 2'b00);
      DS_HALF: misaligned = ofs[0];
      default: misaligned = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_store_align.sv
// Combinational store aligner: replicates right-justified store data across lanes and
// selects byte enables from size and byte offset.
import mem_pkg::*;

module mem_store_align (
  input  logic [1:0]  ds,
  input  logic [1:0]  ofs,
  input  logic [31:0] wdata,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be
);

  // Replicated data lets the memory pick whichever lane the enables select.
  always_comb begin
    mem_wdata = 32'h0000_0000;
    mem_be    = BE_NONE;
    case (ds)
      DS_WORD: begin
        mem_wdata = wdata;
        mem_be    = BE_WORD;
      end
      DS_HALF: begin
        mem_wdata = {2{wdata[15:0]}};
        mem_be    = ofs[1] ? BE_HALF_LO : BE_HALF_HI;
      end
      DS_BYTE: begin
        mem_wdata = {4{wdata[7:0]}};
        mem_be    = byte_be(ofs);
      end
      default: begin
        mem_wdata = 32'h0000_0000;
        mem_be    = BE_NONE;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Single-outstanding load/store port between the MEM stage and data memory (req/ack handshake).
// Define MEM_ALIGN_CHECK_EN to reject misaligned word/half accesses with err instead of issuing them.
import mem_pkg::*;

module mem_access_unit #(
  parameter int TIMEOUT_CYC = 255,
  parameter int CNT_W       = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_ds,
  input  logic        req_bitx,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        rd_valid,
  output logic [31:0] rd_word,
  output logic [1:0]  rd_ofs,
  output logic        rd_bitx,
  output logic [1:0]  rd_ds,
  output logic        done,
  output logic        err,
  output logic        busy
);

  localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYC);
  localparam bit               TIMEOUT_EN  = (TIMEOUT_CYC != 0);

  state_e           state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic             lat_we;
  logic [1:0]       lat_ofs;
  logic [1:0]       lat_ds;
  logic             lat_bitx;
  logic             req_fire;
  logic             bad_req;
  logic [31:0]      al_wdata;
  logic [3:0]       al_be;

  mem_store_align u_align (
    .ds        (req_ds),
    .ofs       (req_addr[1:0]),
    .wdata     (req_wdata),
    .mem_wdata (al_wdata),
    .mem_be    (al_be)
  );

  // Request qualification and timeout counter lookahead.
  always_comb begin
    cnt_next = cnt + CNT_W'(1);
    req_fire = req_valid && req_ready;
`ifdef MEM_ALIGN_CHECK_EN
    bad_req  = (req_ds == DS_INV) || misaligned(req_ds, req_addr[1:0]);
`else
    bad_req  = (req_ds == DS_INV);
`endif
  end

  // Control FSM; every output is registered here so done/err/rd_valid are clean one-cycle pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      lat_we    <= 1'b0;
      lat_ofs   <= 2'b00;
      lat_ds    <= 2'b00;
      lat_bitx  <= 1'b0;
      req_ready <= 1'b1;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 32'h0000_0000;
      mem_wdata <= 32'h0000_0000;
      mem_be    <= BE_NONE;
      rd_valid  <= 1'b0;
      rd_word   <= 32'h0000_0000;
      rd_ofs    <= 2'b00;
      rd_bitx   <= 1'b0;
      rd_ds     <= 2'b00;
      done      <= 1'b0;
      err       <= 1'b0;
      busy      <= 1'b0;
    end else begin
      done     <= 1'b0;
      err      <= 1'b0;
      rd_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req_fire) begin
            lat_we    <= req_we;
            lat_ofs   <= req_addr[1:0];
            lat_ds    <= req_ds;
            lat_bitx  <= req_bitx;
            cnt       <= '0;
            req_ready <= 1'b0;
            busy      <= 1'b1;
            if (bad_req) begin
              state <= ERR;
              err   <= 1'b1;
            end else begin
              state     <= REQ;
              mem_req   <= 1'b1;
              mem_we    <= req_we;
              mem_addr  <= {req_addr[31:2], 2'b00};
              mem_wdata <= req_we ? al_wdata : 32'h0000_0000;
              mem_be    <= req_we ? al_be : BE_WORD;
            end
          end
        end
        REQ: begin
          cnt <= cnt_next;
          // Ack takes priority over a timeout expiring in the same cycle.
          if (mem_ack) begin
            state   <= RESP;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            done    <= 1'b1;
            if (!lat_we) begin
              rd_valid <= 1'b1;
              rd_word  <= mem_rdata;
              rd_ofs   <= lat_ofs;
              rd_ds    <= lat_ds;
              rd_bitx  <= lat_bitx;
            end
          end else if (TIMEOUT_EN && (cnt_next == TIMEOUT_VAL)) begin
            state   <= ERR;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            err     <= 1'b1;
          end
        end
        RESP: begin
          state     <= IDLE;
          req_ready <= 1'b1;
          busy      <= 1'b0;
        end
        ERR: begin
          state     <= IDLE;
          req_ready <= 1'b1;
          busy      <= 1'b0;
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
          busy      <= 1'b0;
          mem_req   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Sequential load/store port between the pipeline MEM stage and the data memory.
- Accepts one request at a time and aligns store data and byte-enables.
- Runs a req/ack handshake with memory and captures the raw read word.
- Presents the read word, byte offset, size and sign-extend bit to the downstream read-data decoder, plus done/err status.
- Big-endian lanes: offset 0 = bits 31:24.

Parameters:
TIMEOUT_CYC, 255, max cycles mem_req may wait for mem_ack before abort; 0 disables the timeout.
CNT_W, 8, timeout counter width; must satisfy TIMEOUT_CYC < 2**CNT_W.

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  pipeline request valid
req_ready  out  1  unit can accept; high only in IDLE
req_we  in  1  1=store, 0=load
req_addr  in  32  byte address
req_wdata  in  32  store data, right-justified
req_ds  in  2  size: 00 word, 01 half, 10 byte, 11 invalid
req_bitx  in  1  load sign-extend flag, passed through
mem_req  out  1  memory request, held until ack
mem_we  out  1  memory write strobe qualifier
mem_addr  out  32  word address, {req_addr[31:2],2'b00}
mem_wdata  out  32  lane-aligned store data
mem_be  out  4  byte enables; bit3 = lane bits 31:24
mem_ack  in  1  memory completion; rdata valid with ack on loads
mem_rdata  in  32  raw read word
rd_valid  out  1  one-cycle pulse: rd_* fields valid (loads only)
rd_word  out  32  captured mem_rdata
rd_ofs  out  2  req_addr[1:0] of the load
rd_bitx  out  1  latched req_bitx
rd_ds  out  2  latched req_ds
done  out  1  one-cycle pulse on successful completion (load or store)
err  out  1  one-cycle pulse on invalid size, timeout or misalignment
busy  out  1  high in any state other than IDLE; pipeline stall

Behaviour:
- Reset values: all outputs 0 except req_ready=1. State=IDLE. Counter=0.
- Reset asserted mid-operation aborts immediately: mem_req drops asynchronously and no done/err is issued.
- All outputs are registered. req_ready equals (state==IDLE).
- States: IDLE, REQ, RESP, ERR.
- IDLE:
  - On req_valid&&req_ready, latch we, addr, wdata, ds and bitx.
  - If ds==11, go to ERR. Otherwise go to REQ with mem_req=1 and mem_addr/mem_wdata/mem_be/mem_we driven from the latched values.
- REQ:
  - mem_req and all mem_* outputs stay stable until mem_ack.
  - mem_ack may arrive in the first REQ cycle.
  - On ack: capture mem_rdata into rd_word, drop mem_req, go to RESP.
  - The counter increments every REQ cycle. If TIMEOUT_CYC!=0 and counter reaches TIMEOUT_CYC without ack: drop mem_req, go to ERR.
  - An ack arriving in the same cycle the counter reaches TIMEOUT_CYC wins: no error.
- RESP (one cycle):
  - Pulse done. For loads, also pulse rd_valid.
  - rd_word/rd_ofs/rd_ds/rd_bitx hold their values until the next load's RESP.
  - Next state IDLE.
- ERR (one cycle): pulse err, no memory access, next state IDLE. rd_valid is not asserted.
- Minimum latency:
  - Accept at cycle 0, mem_req high at cycle 1.
  - With ack at cycle 1, done/rd_valid at cycle 2 and req_ready high at cycle 3.
- Store alignment:
  - Word: wdata, be=1111.
  - Half: data {2{wdata[15:0]}}; be=1100 if ofs[1]=0, 0011 if ofs[1]=1.
  - Byte: data {4{wdata[7:0]}}; be one-hot at bit (3-ofs).
- Loads: mem_we=0, mem_be=1111.
- mem_ack seen outside REQ is ignored.

Optional Feature:
- Macro MEM_ALIGN_CHECK_EN.
- Defined: a word access with addr[1:0]!=0, or a half access with addr[0]=1, goes IDLE->ERR with no memory access and err pulses at cycle 1.
- Undefined: no check. Word ignores addr[1:0]; half uses only addr[1]; the access proceeds normally.

Decomposition:
- Package mem_pkg: DS_WORD/DS_HALF/DS_BYTE/DS_INV encodings, state enum (IDLE, REQ, RESP, ERR), lane/byte-enable constants.
- Sub-module mem_store_align: combinational, (ds, ofs, wdata) -> (mem_wdata, mem_be). Shares its lane mapping with the downstream decoder.

Test Plan:
- Load word addr 0x100, ack at cycle 1 with rdata 0xDEADBEEF -> mem_addr=0x100, be=1111; cycle 2 rd_valid=1, rd_word=0xDEADBEEF, rd_ofs=00, done=1.
- Store byte 0xA5 at addr 0x203, ack after 3 cycles -> mem_addr=0x200, mem_wdata=0xA5A5A5A5, be=0001, mem_req held 3 cycles, done pulse, rd_valid=0.
- Store half 0x1234 at 0x10 and at 0x12 -> be=1100 then 0011, mem_wdata=0x12341234 both times.
- Request with ds=11 -> no mem_req, err=1 at cycle 1, req_ready=1 at cycle 2; no ack with TIMEOUT_CYC=4 -> mem_req high 4 cycles, then err pulse, no rd_valid.
- Assert rst_n low in REQ mid-wait -> mem_req=0 immediately; after release, req_ready=1 and a late ack causes no done.
- With MEM_ALIGN_CHECK_EN, load word at 0x102 -> err at cycle 1, no mem_req; without the macro -> mem_addr=0x100 and normal completion.
